// File: rtl/validador_pecas.sv
// -----------------------------------------------------------------------------
// validador_pecas
//   Responder side of the piece-placement handshake. A rising edge on valida
//   latches a candidate ship. The FSM walks the ship one cell per cycle against
//   the occupancy board of the selected player, reports conflito/pronto and,
//   when the ship fits, commits its cells one per cycle.
//
//   Optional build macro: ADJ_CHECK_EN. When defined, a cell also conflicts if
//   any in-range 8-neighbour is occupied, so ships may not touch.
//
// Parameters
//   TAM         board side; legal coordinates are 0..TAM-1 (TAM <= 16)
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high; clears FSM, outputs and both boards
//   valida      request; a registered 0->1 transition starts a check
//   tipo        ship type; length = tipo+1 (0..4 legal)
//   jogador     board select: 0 CPU, 1 human
//   x1, y1      anchor cell
//   direcao     0 horizontal, 1 vertical
//   orientacao  0 N(y-1) 1 S(y+1) 2 L(x+1) 3 O(x-1); 4..7 illegal
//   limpa       clears board[jogador]; honoured only in IDLE, beats valida
//   rd_jogador  read-port board select
//   rd_x, rd_y  read-port cell
//   rd_ocupado  combinational occupancy of (rd_x, rd_y); 0 when out of range
//   conflito    result of the last check, held until the next result
//   pronto      one-cycle pulse: conflito is valid
//   ocupado     high while the FSM is not IDLE
// -----------------------------------------------------------------------------
module validador_pecas #(
  parameter int TAM = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valida,
  input  logic [2:0] tipo,
  input  logic       jogador,
  input  logic [3:0] x1,
  input  logic [3:0] y1,
  input  logic       direcao,
  input  logic [2:0] orientacao,
  input  logic       limpa,
  input  logic       rd_jogador,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic       rd_ocupado,
  output logic       conflito,
  output logic       pronto,
  output logic       ocupado
);

  localparam int CELLS = TAM * TAM;
  localparam int AW    = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, CHECK, RESP, WRITE} state_t;

  state_t state, next_state;

  logic [CELLS-1:0]  board [2];
  logic              valida_q;
  logic              jog_q;
  logic [3:0]        x_q, y_q;
  logic signed [4:0] dx_q, dy_q;
  logic [2:0]        last_q;     // index of the final cell (len-1)
  logic [2:0]        idx_q;
  logic              conf_q;

  logic              start;
  logic              legal;
  logic signed [4:0] dx_in, dy_in;
  logic signed [4:0] idx_s, cx, cy;
  logic              cell_in, cell_set, cell_bad, adj_hit;
  logic [AW-1:0]     cell_addr, rd_addr;

  assign start = valida & ~valida_q;

  // Request decode: type, orientation range and axis must all agree.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    dx_in = 5'sd0;
    dy_in = 5'sd0;
    case (orientacao[1:0])
      2'd0:    dy_in = -5'sd1;
      2'd1:    dy_in =  5'sd1;
      2'd2:    dx_in =  5'sd1;
      default: dx_in = -5'sd1;
    endcase
    legal = (tipo <= 3'd4) && (orientacao <= 3'd3) &&
            (direcao ? (orientacao <= 3'd1) : (orientacao >= 3'd2));
  end

  // Current cell = anchor + idx*step in 5-bit signed. Anchors reach 15 and
  // steps +-4, so any sum past 15 wraps negative and still reads out of range.
  assign idx_s     = $signed({2'b00, idx_q});
  assign cx        = $signed({1'b0, x_q}) + idx_s * dx_q;
  assign cy        = $signed({1'b0, y_q}) + idx_s * dy_q;
  assign cell_in   = !cx[4] && !cy[4] &&
                     ({1'b0, cx[3:0]} < 5'(TAM)) && ({1'b0, cy[3:0]} < 5'(TAM));
  assign cell_addr = AW'(cy[3:0]) * AW'(TAM) + AW'(cx[3:0]);
  assign cell_set  = cell_in && board[jog_q][cell_addr];

`ifdef ADJ_CHECK_EN
  always_comb begin
    int nx, ny;
    adj_hit = 1'b0;
    nx      = 0;
    ny      = 0;
    for (int ddy = -1; ddy <= 1; ddy++) begin
      for (int ddx = -1; ddx <= 1; ddx++) begin
        nx = int'(cx) + ddx;
        ny = int'(cy) + ddy;
        if (nx >= 0 && nx < TAM && ny >= 0 && ny < TAM &&
            board[jog_q][AW'(ny * TAM + nx)])
          adj_hit = 1'b1;
      end
    end
  end
`else
  assign adj_hit = 1'b0;
`endif

  assign cell_bad = !cell_in || cell_set || adj_hit;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!limpa && start) next_state = CHECK;
      CHECK:   if (idx_q == last_q) next_state = RESP;
      RESP:    next_state = conf_q ? IDLE : WRITE;
      WRITE:   if (idx_q == last_q) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ocupado = (state != IDLE);
  end

  // Datapath, registered results and occupancy boards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the boards are ordinary flops and must come up empty, so
      // they sit in the reset branch rather than in an unreset RAM.
      board[0] <= '0;
      board[1] <= '0;
      valida_q <= 1'b0;
      jog_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      last_q   <= '0;
      idx_q    <= '0;
      conf_q   <= 1'b0;
      conflito <= 1'b0;
      pronto   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values regardless of statement order.
      valida_q <= valida;
      pronto   <= 1'b0;
      case (state)
        IDLE: begin
          if (limpa) begin
            board[jogador] <= '0;
          end else if (start) begin
            jog_q  <= jogador;
            x_q    <= x1;
            y_q    <= y1;
            dx_q   <= dx_in;
            dy_q   <= dy_in;
            idx_q  <= '0;
            // Illegal requests spend one dummy CHECK cycle with conf already
            // set, giving a fixed two-cycle rejection.
            conf_q <= !legal;
            last_q <= legal ? tipo : 3'd0;
          end
        end
        CHECK: begin
          conf_q <= conf_q | cell_bad;
          idx_q  <= idx_q + 3'd1;
        end
        RESP: begin
          conflito <= conf_q;
          pronto   <= 1'b1;
          idx_q    <= '0;
        end
        WRITE: begin
          board[jog_q][cell_addr] <= 1'b1;
          idx_q <= idx_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Read port
  assign rd_addr    = AW'(rd_y) * AW'(TAM) + AW'(rd_x);
  assign rd_ocupado = ({1'b0, rd_x} < 5'(TAM)) && ({1'b0, rd_y} < 5'(TAM)) &&
                      board[rd_jogador][rd_addr];

endmodule
